reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 5, width of register address (32 registers).
REQ-002 Parameter XLEN, default 32, width of register data.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous active-high reset).
REQ-004 wb_stall input 1: when high, no grant is issued in that cycle.
REQ-005 alu_valid input 1: ALU writeback request.
REQ-006 alu_addr input ADDR_SIZE: ALU destination register.
REQ-007 alu_data input XLEN: ALU result.
REQ-008 alu_ready output 1: ALU request accepted in this cycle.
REQ-009 mem_valid input 1: load-unit writeback request.
REQ-010 mem_addr input ADDR_SIZE: load destination register.
REQ-011 mem_data input XLEN: load data.
REQ-012 mem_ready output 1: load request accepted in this cycle.
REQ-013 wr_en output 1: register-file write enable, registered.
REQ-014 wr_addr output ADDR_SIZE: register-file write address, registered.
REQ-015 wr_data output XLEN: register-file write data, registered.
REQ-016 conflict_cnt output 16: number of cycles in which both requesters were valid, not stalled, and one lost arbitration.

Function
REQ-017 A transfer SHALL occur when valid and ready are both high on a rising clk edge.
REQ-018 A requester SHALL hold valid, addr and data stable until its ready is high; the block does not check this.
REQ-019 alu_ready and mem_ready SHALL be combinational from the valids, wb_stall and the priority pointer; at most one is high per cycle.
REQ-020 With wb_stall high, both readys SHALL be 0 and the pointer SHALL hold.
REQ-021 With exactly one valid and no stall, that requester SHALL be granted.
REQ-022 With both valid and no stall, the grant SHALL follow the arbitration rule in REQ-034/REQ-035, and conflict_cnt SHALL increment.
REQ-023 conflict_cnt SHALL saturate at 0xFFFF.
REQ-024 A granted request SHALL appear on wr_en/wr_addr/wr_data exactly 1 cycle after the transfer edge; latency is 1, throughput is 1 write per cycle.
REQ-025 A granted request with addr 0 SHALL be accepted (ready high) but dropped: wr_en 0 in the following cycle, because x0 is never written.
REQ-026 In cycles with no transfer, wr_en SHALL be 0 in the next cycle; wr_addr and wr_data hold their last values.
REQ-027 Both requesters targeting the same address in the same cycle SHALL be serialized; the regfile holds the data of the later grant.
REQ-028 The priority pointer is 1 bit with states PRI_ALU and PRI_MEM; it SHALL update only on a grant.

Reset
REQ-029 While rst is high at a clk edge: wr_en←0, wr_addr←0, wr_data←0, conflict_cnt←0, pointer←PRI_MEM.
REQ-030 alu_ready and mem_ready SHALL be 0 in any cycle in which rst is high.
REQ-031 A transfer that would coincide with a reset edge SHALL not occur.
REQ-032 A write already registered when rst rises SHALL be discarded: wr_en reads 0 in the cycle after the reset edge.
REQ-033 Requests SHALL be granted from the first cycle after rst falls.

Configuration
REQ-034 With macro WB_ROUND_ROBIN_EN defined: on a conflict the pointer owner wins; after any grant the pointer moves to the other requester.
REQ-035 With WB_ROUND_ROBIN_EN undefined: fixed priority, mem wins every conflict, and the pointer register is absent; conflict_cnt behaves identically.

Verification
REQ-036 Reset, then alu_valid=1, alu_addr=3, alu_data=0x11 for one cycle -> alu_ready=1 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x11.
REQ-037 Both valid for 4 cycles (alu addr 1 data 0xA, mem addr 2 data 0xB), requesters holding each until granted then re-presenting the same values -> round-robin grants mem, alu, mem, alu; fixed priority grants mem for all 4; conflict_cnt=4 in both builds.
REQ-038 mem_valid=1, mem_addr=0, mem_data=0xFF -> mem_ready=1; next cycle wr_en=0.
REQ-039 Both valid with wb_stall=1 for 3 cycles -> readys 0, wr_en 0, conflict_cnt unchanged; on stall release, mem is granted first.
REQ-040 Grant alu (addr 5), then assert rst on the following edge -> wr_en=0 after the reset edge, conflict_cnt=0; force conflict_cnt to 0xFFFF and create a conflict -> conflict_cnt stays 0xFFFF.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// Writeback request/grant bundle between the ALU, load unit and regfile port.
// master drives requests, slave is the arbiter.
interface reg_wb_arbiter_if #(
  parameter int ADDR_SIZE = 5,
  parameter int XLEN      = 32
);
  logic                 wb_stall;
  logic                 alu_valid;
  logic [ADDR_SIZE-1:0] alu_addr;
  logic [XLEN-1:0]      alu_data;
  logic                 alu_ready;
  logic                 mem_valid;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_ready;
  logic                 wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic [15:0]          conflict_cnt;

  modport master (
    output wb_stall,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  wr_en, wr_addr, wr_data,
    input  conflict_cnt
  );

  modport slave (
    input  wb_stall,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output wr_en, wr_addr, wr_data,
    output conflict_cnt
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester regfile writeback arbiter with registered write port.
// Define WB_ROUND_ROBIN_EN for round-robin; default is fixed mem priority.
module reg_wb_arbiter #(
  parameter int ADDR_SIZE = 5,
  parameter int XLEN      = 32
) (
  input logic            clk,
  input logic            rst,
  reg_wb_arbiter_if.slave bus
);

  logic                 both;
  logic                 alu_gnt;
  logic                 mem_gnt;
  logic                 wen_q;
  logic [ADDR_SIZE-1:0] waddr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [15:0]          cnt_q;

`ifdef WB_ROUND_ROBIN_EN
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

  pri_e pri_q;
  pri_e pri_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= PRI_MEM;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Pointer hands priority to the other side after any grant.
  always_comb begin
    pri_d = pri_q;
    if (alu_gnt) begin
      pri_d = PRI_MEM;
    end else if (mem_gnt) begin
      pri_d = PRI_ALU;
    end
  end
`endif

  assign both = bus.alu_valid && bus.mem_valid;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!rst && !bus.wb_stall) begin
      if (both) begin
`ifdef WB_ROUND_ROBIN_EN
        if (pri_q == PRI_ALU) begin
          alu_gnt = 1'b1;
        end else begin
          mem_gnt = 1'b1;
        end
`else
        mem_gnt = 1'b1;
`endif
      end else begin
        alu_gnt = bus.alu_valid;
        mem_gnt = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;

  // x0 grants are accepted but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= 1'b0;
      if (alu_gnt && (bus.alu_addr != '0)) begin
        wen_q   <= 1'b1;
        waddr_q <= bus.alu_addr;
        wdata_q <= bus.alu_data;
      end else if (mem_gnt && (bus.mem_addr != '0)) begin
        wen_q   <= 1'b1;
        waddr_q <= bus.mem_addr;
        wdata_q <= bus.mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (both && !bus.wb_stall && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.wr_en        = wen_q;
  assign bus.wr_addr      = waddr_q;
  assign bus.wr_data      = wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: cycle model plus literal pins.
// Build with or without WB_ROUND_ROBIN_EN to match the DUT.
module tb_reg_wb_arbiter;

  logic clk = 1'b0;
  logic rst;

  reg_wb_arbiter_if #(.ADDR_SIZE(5), .XLEN(32)) bus ();

  reg_wb_arbiter #(.ADDR_SIZE(5), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 0;

  // model state: own 0 = alu holds priority, 1 = mem
  int          own;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt;
  int          gq[$];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic void m_grant(output bit ga, output bit gm);
    ga = 0;
    gm = 0;
    if (rst || bus.wb_stall) return;
    if (bus.alu_valid && bus.mem_valid) begin
`ifdef WB_ROUND_ROBIN_EN
      if (own == 0) ga = 1;
      else gm = 1;
`else
      gm = 1;
`endif
    end else begin
      ga = bus.alu_valid;
      gm = bus.mem_valid;
    end
  endfunction

  always @(posedge clk) begin
    bit ga, gm;
    m_grant(ga, gm);
    if (rst) begin
      m_wen   = 0;
      m_waddr = '0;
      m_wdata = '0;
      m_cnt   = 0;
      own     = 1;
    end else begin
      if (bus.alu_valid && bus.mem_valid && !bus.wb_stall)
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      m_wen = 0;
      if (ga) begin
        gq.push_back(1);
        own = 1;
        if (bus.alu_addr != 0) begin
          m_wen   = 1;
          m_waddr = bus.alu_addr;
          m_wdata = bus.alu_data;
        end
      end else if (gm) begin
        gq.push_back(2);
        own = 0;
        if (bus.mem_addr != 0) begin
          m_wen   = 1;
          m_waddr = bus.mem_addr;
          m_wdata = bus.mem_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ga, gm;
    if (run_chk) begin
      m_grant(ga, gm);
      chk("model_alu_ready", bus.alu_ready, ga);
      chk("model_mem_ready", bus.mem_ready, gm);
      chk("model_wr_en", bus.wr_en, m_wen);
      if (m_wen) begin
        chk("model_wr_addr", bus.wr_addr, m_waddr);
        chk("model_wr_data", bus.wr_data, m_wdata);
      end
      chk("model_conflict_cnt", bus.conflict_cnt, m_cnt);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wb_stall  = 0;
    bus.alu_valid = 0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    bit          st;
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          mv;
    logic [4:0]  ma;
    logic [31:0] md;
  } vec_t;

  vec_t tv[7];
  int   exp_seq[4];
  bit   pa, pm;

  initial begin
    rst = 1;
    idle();
    step();
    run_chk = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);

    // single alu write
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd3;
    bus.alu_data  = 32'h11;
    @(negedge clk);
    chk("alu_single_ready", bus.alu_ready, 1);
    step();
    idle();
    @(negedge clk);
    chk("alu_single_wr_en", bus.wr_en, 1);
    chk("alu_single_wr_addr", bus.wr_addr, 3);
    chk("alu_single_wr_data", bus.wr_data, 32'h11);
    step();
    @(negedge clk);
    chk("idle_wr_en", bus.wr_en, 0);

    // x0 load dropped
    bus.mem_valid = 1;
    bus.mem_addr  = 5'd0;
    bus.mem_data  = 32'hFF;
    @(negedge clk);
    chk("x0_mem_ready", bus.mem_ready, 1);
    step();
    idle();
    @(negedge clk);
    chk("x0_wr_en", bus.wr_en, 0);

    // four-cycle conflict
    do_reset();
    gq.delete();
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd1;
    bus.alu_data  = 32'hA;
    bus.mem_valid = 1;
    bus.mem_addr  = 5'd2;
    bus.mem_data  = 32'hB;
    repeat (4) step();
    idle();
`ifdef WB_ROUND_ROBIN_EN
    exp_seq = '{2, 1, 2, 1};
`else
    exp_seq = '{2, 2, 2, 2};
`endif
    chk("conflict_gnt_count", gq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk($sformatf("conflict_gnt%0d", i), gq[i], exp_seq[i]);
    end
    @(negedge clk);
    chk("conflict_cnt4", bus.conflict_cnt, 4);

    // stalled conflict, then release
    do_reset();
    bus.wb_stall  = 1;
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd4;
    bus.alu_data  = 32'h44;
    bus.mem_valid = 1;
    bus.mem_addr  = 5'd6;
    bus.mem_data  = 32'h66;
    repeat (3) begin
      @(negedge clk);
      chk("stall_alu_ready", bus.alu_ready, 0);
      chk("stall_mem_ready", bus.mem_ready, 0);
      step();
    end
    bus.wb_stall = 0;
    @(negedge clk);
    chk("stall_wr_en", bus.wr_en, 0);
    chk("stall_cnt", bus.conflict_cnt, 0);
    chk("release_mem_ready", bus.mem_ready, 1);
    chk("release_alu_ready", bus.alu_ready, 0);
    step();
    idle();
    step();

    // same destination from both sides, later grant wins
    do_reset();
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd7;
    bus.alu_data  = 32'hA7;
    bus.mem_valid = 1;
    bus.mem_addr  = 5'd7;
    bus.mem_data  = 32'hB7;
    repeat (2) begin
      @(negedge clk);
      pa = bus.alu_ready;
      pm = bus.mem_ready;
      step();
      if (pa) bus.alu_valid = 0;
      if (pm) bus.mem_valid = 0;
    end
    idle();
    @(negedge clk);
    chk("same_addr_wr_en", bus.wr_en, 1);
    chk("same_addr_wr_addr", bus.wr_addr, 7);
    chk("same_addr_wr_data", bus.wr_data, 32'hA7);

    // mixed directed vectors, model-checked
    tv[0] = '{0, 1, 5'd9,  32'h900D, 0, 5'd0,  32'h0};
    tv[1] = '{0, 0, 5'd0,  32'h0,    1, 5'd12, 32'hC0DE};
    tv[2] = '{0, 1, 5'd0,  32'hDEAD, 0, 5'd0,  32'h0};
    tv[3] = '{1, 1, 5'd8,  32'h8,    0, 5'd0,  32'h0};
    tv[4] = '{0, 1, 5'd31, 32'h1F1F, 1, 5'd30, 32'h3030};
    tv[5] = '{0, 1, 5'd31, 32'h1F1F, 1, 5'd30, 32'h3030};
    tv[6] = '{0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0};
    foreach (tv[i]) begin
      bus.wb_stall  = tv[i].st;
      bus.alu_valid = tv[i].av;
      bus.alu_addr  = tv[i].aa;
      bus.alu_data  = tv[i].ad;
      bus.mem_valid = tv[i].mv;
      bus.mem_addr  = tv[i].ma;
      bus.mem_data  = tv[i].md;
      step();
    end
    idle();

    // reset discards a pending write
    do_reset();
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'h55;
    step();
    idle();
    rst = 1;
    @(negedge clk);
    chk("pre_rst_wr_en", bus.wr_en, 1);
    chk("rst_cycle_no_ready", bus.alu_ready, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_wr_en", bus.wr_en, 0);
    chk("post_rst_cnt", bus.conflict_cnt, 0);

    // saturation
    step();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    bus.alu_valid = 1;
    bus.alu_addr  = 5'd2;
    bus.alu_data  = 32'h2;
    bus.mem_valid = 1;
    bus.mem_addr  = 5'd3;
    bus.mem_data  = 32'h3;
    step();
    step();
    idle();
    @(negedge clk);
    chk("sat_cnt", bus.conflict_cnt, 16'hFFFF);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
